reservation_station: RTL and testbench

//   Integer reservation station feeding the ALU. Buffers dispatched ALU/branch/jump ops, holds

---
 rtl/reservation_station.sv | 199 +++++++++++++++++++
 tb/tb_reservation_station.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: integer RS buffering ALU/branch ops, CDB wakeup, one registered issue per cycle.
// Define RS_AGE_SELECT_EN for oldest-ready-first select; otherwise lowest-index ready wins.
module reservation_station #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4
`ifdef RS_AGE_SELECT_EN
    ,
    parameter int AGE_W   = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             issue_sgn,
    input  logic [5:0]       issue_opcode,
    input  logic [31:0]      issue_vj,
    input  logic [ROB_W-1:0] issue_qj,
    input  logic             issue_qj_wait,
    input  logic [31:0]      issue_vk,
    input  logic [ROB_W-1:0] issue_qk,
    input  logic             issue_qk_wait,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic [ROB_W-1:0] issue_rob,
    output logic             rs_full,
    input  logic             alu_cdb_sgn,
    input  logic [ROB_W-1:0] alu_cdb_rob,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_sgn,
    input  logic [ROB_W-1:0] lsb_cdb_rob,
    input  logic [31:0]      lsb_cdb_val,
    output logic             RS_sgn,
    output logic [5:0]       RS_opcode,
    output logic [31:0]      lhs,
    output logic [31:0]      rhs,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [5:0]       ROB_entry
);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d, qjw_q, qjw_d, qkw_q, qkw_d, ready;
    logic [5:0]         op_q [RS_SIZE], op_d [RS_SIZE];
    logic [31:0]        vj_q [RS_SIZE], vj_d [RS_SIZE], vk_q [RS_SIZE], vk_d [RS_SIZE];
    logic [31:0]        im_q [RS_SIZE], im_d [RS_SIZE], pc_q [RS_SIZE], pc_d [RS_SIZE];
    logic [ROB_W-1:0]   qj_q [RS_SIZE], qj_d [RS_SIZE], qk_q [RS_SIZE], qk_d [RS_SIZE];
    logic [ROB_W-1:0]   rob_q [RS_SIZE], rob_d [RS_SIZE];
`ifdef RS_AGE_SELECT_EN
    logic [AGE_W-1:0]   age_q [RS_SIZE], age_d [RS_SIZE];
`endif
    logic               sgn_q, sgn_d;
    logic [5:0]         op_o_q, op_o_d;
    logic [31:0]        lhs_q, lhs_d, rhs_q, rhs_d, imm_o_q, imm_o_d, pc_o_q, pc_o_d;
    logic [ROB_W-1:0]   rob_o_q, rob_o_d;
    logic               sel_found;
    logic [IW-1:0]      sel_idx, free_idx;
    logic               aj, lj, ak, lk, dj_w, dk_w;
    logic [31:0]        dj_v, dk_v;

    // Same-cycle CDB bypass for the operands being dispatched
    assign aj   = alu_cdb_sgn && alu_cdb_rob == issue_qj;
    assign lj   = lsb_cdb_sgn && lsb_cdb_rob == issue_qj;
    assign ak   = alu_cdb_sgn && alu_cdb_rob == issue_qk;
    assign lk   = lsb_cdb_sgn && lsb_cdb_rob == issue_qk;
    assign dj_v = issue_qj_wait && aj ? alu_cdb_val : issue_qj_wait && lj ? lsb_cdb_val : issue_vj;
    assign dk_v = issue_qk_wait && ak ? alu_cdb_val : issue_qk_wait && lk ? lsb_cdb_val : issue_vk;
    assign dj_w = issue_qj_wait && !aj && !lj;
    assign dk_w = issue_qk_wait && !ak && !lk;

    assign rs_full   = &busy_q;
    assign ready     = busy_q & ~qjw_q & ~qkw_q;
    assign RS_sgn    = sgn_q & rdy;
    assign RS_opcode = op_o_q;
    assign lhs       = lhs_q;
    assign rhs       = rhs_q;
    assign imm       = imm_o_q;
    assign pc        = pc_o_q;
    assign ROB_entry = 6'(rob_o_q);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_AGE_SELECT_EN
        for (int i = 0; i < RS_SIZE; i++)
            if (ready[i] && (!sel_found || age_q[i] > age_q[sel_idx])) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
`else
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
`endif
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!busy_q[i] || (sel_found && sel_idx == IW'(i))) free_idx = IW'(i);
        busy_d = busy_q;
        qjw_d  = qjw_q;
        qkw_d  = qkw_q;
        op_d   = op_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        im_d   = im_q;
        pc_d   = pc_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        rob_d  = rob_q;
`ifdef RS_AGE_SELECT_EN
        age_d  = age_q;
`endif
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && qjw_q[i] && alu_cdb_sgn && qj_q[i] == alu_cdb_rob) begin
                vj_d[i]  = alu_cdb_val;
                qjw_d[i] = 1'b0;
            end else if (busy_q[i] && qjw_q[i] && lsb_cdb_sgn && qj_q[i] == lsb_cdb_rob) begin
                vj_d[i]  = lsb_cdb_val;
                qjw_d[i] = 1'b0;
            end
            if (busy_q[i] && qkw_q[i] && alu_cdb_sgn && qk_q[i] == alu_cdb_rob) begin
                vk_d[i]  = alu_cdb_val;
                qkw_d[i] = 1'b0;
            end else if (busy_q[i] && qkw_q[i] && lsb_cdb_sgn && qk_q[i] == lsb_cdb_rob) begin
                vk_d[i]  = lsb_cdb_val;
                qkw_d[i] = 1'b0;
            end
`ifdef RS_AGE_SELECT_EN
            age_d[i] = busy_q[i] && age_q[i] != '1 ? age_q[i] + 1'b1 : age_q[i];
`endif
        end
        sgn_d   = sel_found;
        op_o_d  = sel_found ? op_q[sel_idx]  : op_o_q;
        lhs_d   = sel_found ? vj_q[sel_idx]  : lhs_q;
        rhs_d   = sel_found ? vk_q[sel_idx]  : rhs_q;
        imm_o_d = sel_found ? im_q[sel_idx]  : imm_o_q;
        pc_o_d  = sel_found ? pc_q[sel_idx]  : pc_o_q;
        rob_o_d = sel_found ? rob_q[sel_idx] : rob_o_q;
        if (sel_found) busy_d[sel_idx] = 1'b0;
        if (issue_sgn && !rs_full) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = issue_opcode;
            vj_d[free_idx]   = dj_v;
            qjw_d[free_idx]  = dj_w;
            qj_d[free_idx]   = issue_qj;
            vk_d[free_idx]   = dk_v;
            qkw_d[free_idx]  = dk_w;
            qk_d[free_idx]   = issue_qk;
            im_d[free_idx]   = issue_imm;
            pc_d[free_idx]   = issue_pc;
            rob_d[free_idx]  = issue_rob;
`ifdef RS_AGE_SELECT_EN
            age_d[free_idx]  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            busy_q  <= '0;
            sgn_q   <= 1'b0;
            op_o_q  <= '0;
            lhs_q   <= '0;
            rhs_q   <= '0;
            imm_o_q <= '0;
            pc_o_q  <= '0;
            rob_o_q <= '0;
        end else if (rdy) begin
            busy_q  <= busy_d;
            sgn_q   <= sgn_d;
            op_o_q  <= op_o_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            imm_o_q <= imm_o_d;
            pc_o_q  <= pc_o_d;
            rob_o_q <= rob_o_d;
        end
    end

    // Entry payload is only meaningful while busy, so it needs no reset
    always_ff @(posedge clk) begin
        if (rdy) begin
            qjw_q <= qjw_d;
            qkw_q <= qkw_d;
            op_q  <= op_d;
            vj_q  <= vj_d;
            vk_q  <= vk_d;
            im_q  <= im_d;
            pc_q  <= pc_d;
            qj_q  <= qj_d;
            qk_q  <= qk_d;
            rob_q <= rob_d;
`ifdef RS_AGE_SELECT_EN
            age_q <= age_d;
`endif
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed checks of dispatch, wakeup, bypass, full, rollback, select order, rdy stall.
module tb_reservation_station;
    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
    logic        issue_sgn = 1'b0, issue_qj_wait = 1'b0, issue_qk_wait = 1'b0;
    logic [5:0]  issue_opcode = '0;
    logic [31:0] issue_vj = '0, issue_vk = '0, issue_imm = '0, issue_pc = '0;
    logic [3:0]  issue_qj = '0, issue_qk = '0, issue_rob = '0;
    logic        rs_full;
    logic        alu_cdb_sgn = 1'b0, lsb_cdb_sgn = 1'b0;
    logic [3:0]  alu_cdb_rob = '0, lsb_cdb_rob = '0;
    logic [31:0] alu_cdb_val = '0, lsb_cdb_val = '0;
    logic        RS_sgn;
    logic [5:0]  RS_opcode, ROB_entry;
    logic [31:0] lhs, rhs, imm, pc;
    int          n_tests = 0, n_fail = 0;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_sgn(issue_sgn), .issue_opcode(issue_opcode),
        .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_qj_wait(issue_qj_wait),
        .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_qk_wait(issue_qk_wait),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob(issue_rob),
        .rs_full(rs_full),
        .alu_cdb_sgn(alu_cdb_sgn), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_sgn(lsb_cdb_sgn), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
        .RS_sgn(RS_sgn), .RS_opcode(RS_opcode), .lhs(lhs), .rhs(rhs),
        .imm(imm), .pc(pc), .ROB_entry(ROB_entry)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_issue(input logic [5:0] op, input logic [31:0] vj, input logic [3:0] qj,
                             input logic qjw, input logic [31:0] vk, input logic [3:0] qk,
                             input logic qkw, input logic [31:0] im, input logic [3:0] rob);
        issue_sgn     = 1'b1;
        issue_opcode  = op;
        issue_vj      = vj;
        issue_qj      = qj;
        issue_qj_wait = qjw;
        issue_vk      = vk;
        issue_qk      = qk;
        issue_qk_wait = qkw;
        issue_imm     = im;
        issue_pc      = 32'h1000 + 32'(rob);
        issue_rob     = rob;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] vj, input logic [3:0] qj,
                            input logic qjw, input logic [31:0] vk, input logic [3:0] qk,
                            input logic qkw, input logic [31:0] im, input logic [3:0] rob);
        set_issue(op, vj, qj, qjw, vk, qk, qkw, im, rob);
        tick();
        issue_sgn = 1'b0;
    endtask

    task automatic alu_bcast(input logic [3:0] rob, input logic [31:0] val);
        alu_cdb_sgn = 1'b1;
        alu_cdb_rob = rob;
        alu_cdb_val = val;
    endtask

`ifdef RS_AGE_SELECT_EN
    localparam logic [5:0] FIRST_ROB = 6'd13, SECOND_ROB = 6'd14;
`else
    localparam logic [5:0] FIRST_ROB = 6'd14, SECOND_ROB = 6'd13;
`endif

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("init_full", 32'(rs_full), 0);
        check("init_sgn", 32'(RS_sgn), 0);

        dispatch(6'd2, 32'd5, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd3, 4'd2);
        check("addi_not_yet", 32'(RS_sgn), 0);
        tick();
        check("addi_sgn", 32'(RS_sgn), 1);
        check("addi_lhs", lhs, 32'd5);
        check("addi_imm", imm, 32'd3);
        check("addi_rob", 32'(ROB_entry), 2);
        check("addi_op", 32'(RS_opcode), 2);
        check("addi_pc", pc, 32'h1002);
        tick();
        check("addi_once", 32'(RS_sgn), 0);
        check("addi_hold_lhs", lhs, 32'd5);

        dispatch(6'd1, 32'd0, 4'd4, 1'b1, 32'd7, 4'd0, 1'b0, 32'd0, 4'd5);
        tick();
        check("add_wait", 32'(RS_sgn), 0);
        alu_bcast(4'd4, 32'h10);
        tick();
        alu_cdb_sgn = 1'b0;
        check("add_wake_edge", 32'(RS_sgn), 0);
        tick();
        check("add_sgn", 32'(RS_sgn), 1);
        check("add_lhs", lhs, 32'h10);
        check("add_rhs", rhs, 32'd7);
        check("add_rob", 32'(ROB_entry), 5);

        lsb_cdb_sgn = 1'b1;
        lsb_cdb_rob = 4'd7;
        lsb_cdb_val = 32'd9;
        dispatch(6'd3, 32'd1, 4'd0, 1'b0, 32'd0, 4'd7, 1'b1, 32'd0, 4'd6);
        lsb_cdb_sgn = 1'b0;
        tick();
        check("byp_sgn", 32'(RS_sgn), 1);
        check("byp_rhs", rhs, 32'd9);
        check("byp_lhs", lhs, 32'd1);
        check("byp_rob", 32'(ROB_entry), 6);

        for (int i = 0; i < 7; i++) dispatch(6'd1, 0, 4'd1, 1'b1, 0, 4'd0, 1'b0, 0, 4'(i));
        check("seven_not_full", 32'(rs_full), 0);
        dispatch(6'd1, 0, 4'd1, 1'b1, 0, 4'd0, 1'b0, 0, 4'd7);
        check("full", 32'(rs_full), 1);
        dispatch(6'd2, 32'd99, 4'd0, 1'b0, 0, 4'd0, 1'b0, 0, 4'd9);
        check("full_hold", 32'(rs_full), 1);
        tick();
        check("full_drop", 32'(RS_sgn), 0);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("rb_full", 32'(rs_full), 0);
        check("rb_lhs", lhs, 0);
        check("rb_rob", 32'(ROB_entry), 0);
        alu_bcast(4'd1, 32'h55);
        tick();
        alu_cdb_sgn = 1'b0;
        tick();
        check("rb_no_issue", 32'(RS_sgn), 0);

        dispatch(6'd1, 0, 4'd1, 1'b1, 0, 4'd0, 1'b0, 0, 4'd10);
        dispatch(6'd1, 0, 4'd2, 1'b1, 0, 4'd0, 1'b0, 0, 4'd11);
        dispatch(6'd1, 0, 4'd3, 1'b1, 0, 4'd0, 1'b0, 0, 4'd12);
        dispatch(6'd1, 0, 4'd4, 1'b1, 0, 4'd0, 1'b0, 0, 4'd13);
        alu_bcast(4'd1, 32'd1);
        tick();
        alu_cdb_sgn = 1'b0;
        tick();
        check("age_e0_out", 32'(ROB_entry), 10);
        dispatch(6'd1, 0, 4'd6, 1'b1, 0, 4'd0, 1'b0, 0, 4'd14);
        alu_bcast(4'd4, 32'd4);
        lsb_cdb_sgn = 1'b1;
        lsb_cdb_rob = 4'd6;
        lsb_cdb_val = 32'd6;
        tick();
        alu_cdb_sgn = 1'b0;
        lsb_cdb_sgn = 1'b0;
        tick();
        check("sel_first", 32'(ROB_entry), 32'(FIRST_ROB));
        tick();
        check("sel_second", 32'(ROB_entry), 32'(SECOND_ROB));
        check("sel_second_sgn", 32'(RS_sgn), 1);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;

        dispatch(6'd5, 32'h77, 4'd0, 1'b0, 0, 4'd0, 1'b0, 0, 4'd3);
        tick();
        check("stall_pre", 32'(RS_sgn), 1);
        rdy = 1'b0;
        #1;
        check("stall_gate", 32'(RS_sgn), 0);
        set_issue(6'd2, 32'h88, 4'd0, 1'b0, 0, 4'd0, 1'b0, 0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_sgn", 32'(RS_sgn), 0);
            check("stall_lhs", lhs, 32'h77);
        end
        issue_sgn = 1'b0;
        rdy = 1'b1;
        #1;
        check("stall_resume", 32'(RS_sgn), 1);
        check("stall_rob", 32'(ROB_entry), 3);
        tick();
        check("stall_once", 32'(RS_sgn), 0);
        tick();
        check("stall_drop", 32'(RS_sgn), 0);

        for (int i = 0; i < 3; i++) dispatch(6'd1, 0, 4'd2, 1'b1, 0, 4'd0, 1'b0, 0, 4'(i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_full", 32'(rs_full), 0);
        check("rst_sgn", 32'(RS_sgn), 0);
        check("rst_lhs", lhs, 0);
        check("rst_imm", imm, 0);
        check("rst_rob", 32'(ROB_entry), 0);
        alu_bcast(4'd2, 32'd2);
        tick();
        alu_cdb_sgn = 1'b0;
        tick();
        check("rst_no_issue", 32'(RS_sgn), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
